// File: rtl/ptt_link_scheduler.sv
// rtl/ptt_link_scheduler.sv - PTT debounce and half-duplex link turnaround sequencer
// Optional TX timeout watchdog: define PTT_TIMEOUT_EN
module ptt_link_scheduler #(
  parameter int DEBOUNCE_CYCLES   = 50000,
  parameter int GUARD_CYCLES      = 256,
  parameter int SYNC_INTERVAL     = 32,
  parameter int TX_TIMEOUT_CYCLES = 500000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ptt_raw,
  input  logic       spi_tx_busy,
  input  logic       sync_ack,
  input  logic       frame_done,
  output logic       ptt_clean,
  output logic       master_mode,
  output logic       audio_tx_en,
  output logic       sync_req,
  output logic       key_reseed,
  output logic [2:0] state_dbg,
  output logic [7:0] sync_count,
  output logic       timeout_flag
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GW  = $clog2(GUARD_CYCLES + 1);
  localparam int FW  = $clog2(SYNC_INTERVAL + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [GW-1:0]  G_LAST  = GW'(GUARD_CYCLES - 1);
  localparam logic [FW-1:0]  SI_LAST = FW'(SYNC_INTERVAL - 1);

  typedef enum logic [2:0] {
    ST_RX       = 3'd0,
    ST_TX_GUARD = 3'd1,
    ST_TX_SYNC  = 3'd2,
    ST_TX_AUDIO = 3'd3,
    ST_TX_DRAIN = 3'd4,
    ST_RX_GUARD = 3'd5
  } state_t;

  logic           sync1_q, sync1_d, sync2_q, sync2_d;
  logic           ptt_clean_q, ptt_clean_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  state_t         state_q, state_d;
  logic [GW-1:0]  guard_cnt_q, guard_cnt_d;
  logic [FW-1:0]  frame_cnt_q, frame_cnt_d;
  logic [7:0]     sync_count_q, sync_count_d;
  logic           master_mode_q, master_mode_d;
  logic           audio_tx_en_q, audio_tx_en_d;
  logic           sync_req_q, sync_req_d;
  logic           key_reseed_q, key_reseed_d;
  logic           tx_expired;
  logic           rx_hold;
  logic           timeout_set;

  // Synchronize the button and debounce: toggle after DEBOUNCE_CYCLES differing samples
  always_comb begin
    sync1_d     = ptt_raw;
    sync2_d     = sync1_q;
    ptt_clean_d = ptt_clean_q;
    db_cnt_d    = '0;
    if (sync2_q != ptt_clean_q) begin
      if (db_cnt_q == DB_LAST) begin
        ptt_clean_d = ~ptt_clean_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Link sequencer next state, counters and registered per-state outputs
  always_comb begin
    state_d      = state_q;
    guard_cnt_d  = guard_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    sync_count_d = sync_count_q;
    timeout_set  = 1'b0;
    case (state_q)
      ST_RX: begin
        if (ptt_clean_q && !rx_hold) begin
          state_d     = ST_TX_GUARD;
          guard_cnt_d = G_LAST;
        end
      end
      ST_TX_GUARD: begin
        if (!ptt_clean_q) begin
          state_d = ST_RX;
        end else if (tx_expired) begin
          state_d     = ST_TX_DRAIN;
          timeout_set = 1'b1;
        end else if (guard_cnt_q == '0) begin
          state_d = ST_TX_SYNC;
        end else begin
          guard_cnt_d = guard_cnt_q - 1'b1;
        end
      end
      ST_TX_SYNC: begin
        // The request is only retired by the ack, never by a release
        if (sync_ack) begin
          sync_count_d = sync_count_q + 8'd1;
          frame_cnt_d  = '0;
          if (tx_expired) begin
            state_d     = ST_TX_DRAIN;
            timeout_set = 1'b1;
          end else if (ptt_clean_q) begin
            state_d = ST_TX_AUDIO;
          end else begin
            state_d = ST_TX_DRAIN;
          end
        end
      end
      ST_TX_AUDIO: begin
        if (frame_done) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
        // Release takes priority over a re-sync due on the same frame
        if (tx_expired) begin
          state_d     = ST_TX_DRAIN;
          timeout_set = 1'b1;
        end else if (!ptt_clean_q) begin
          state_d = ST_TX_DRAIN;
        end else if (frame_done && (frame_cnt_q == SI_LAST)) begin
          state_d = ST_TX_SYNC;
        end
      end
      ST_TX_DRAIN: begin
        if (!spi_tx_busy) begin
          state_d     = ST_RX_GUARD;
          guard_cnt_d = G_LAST;
        end
      end
      ST_RX_GUARD: begin
        if (guard_cnt_q == '0) begin
          state_d = ST_RX;
        end else begin
          guard_cnt_d = guard_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_RX;
      end
    endcase
    master_mode_d = (state_d == ST_TX_GUARD) || (state_d == ST_TX_SYNC) ||
                    (state_d == ST_TX_AUDIO) || (state_d == ST_TX_DRAIN);
    audio_tx_en_d = (state_d == ST_TX_AUDIO);
    sync_req_d    = (state_d == ST_TX_SYNC);
    key_reseed_d  = (state_q == ST_TX_GUARD) && (state_d == ST_TX_SYNC);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      ptt_clean_q   <= 1'b0;
      db_cnt_q      <= '0;
      state_q       <= ST_RX;
      guard_cnt_q   <= '0;
      frame_cnt_q   <= '0;
      sync_count_q  <= '0;
      master_mode_q <= 1'b0;
      audio_tx_en_q <= 1'b0;
      sync_req_q    <= 1'b0;
      key_reseed_q  <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      ptt_clean_q   <= ptt_clean_d;
      db_cnt_q      <= db_cnt_d;
      state_q       <= state_d;
      guard_cnt_q   <= guard_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      sync_count_q  <= sync_count_d;
      master_mode_q <= master_mode_d;
      audio_tx_en_q <= audio_tx_en_d;
      sync_req_q    <= sync_req_d;
      key_reseed_q  <= key_reseed_d;
    end
  end

`ifdef PTT_TIMEOUT_EN
  localparam int TW = $clog2(TX_TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TX_TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tx_timer_q, tx_timer_d;
  logic          timeout_flag_q, timeout_flag_d;

  // TX timer: zero while idle in RX, saturating count through the TX states
  always_comb begin
    tx_timer_d     = tx_timer_q;
    timeout_flag_d = timeout_flag_q;
    if (state_q == ST_RX) begin
      tx_timer_d = '0;
    end else if ((state_q != ST_RX_GUARD) && (tx_timer_q != TO_LAST)) begin
      tx_timer_d = tx_timer_q + 1'b1;
    end
    if (timeout_set) begin
      timeout_flag_d = 1'b1;
    end else if ((state_q == ST_RX) && !ptt_clean_q) begin
      timeout_flag_d = 1'b0;
    end
  end

  // Timeout registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_timer_q     <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      tx_timer_q     <= tx_timer_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  assign tx_expired   = (tx_timer_q == TO_LAST);
  assign rx_hold      = timeout_flag_q;
  assign timeout_flag = timeout_flag_q;
`else
  logic unused_timeout;

  assign tx_expired     = 1'b0;
  assign rx_hold        = 1'b0;
  assign timeout_flag   = 1'b0;
  assign unused_timeout = timeout_set ^ (TX_TIMEOUT_CYCLES != 0);
`endif

  assign ptt_clean   = ptt_clean_q;
  assign master_mode = master_mode_q;
  assign audio_tx_en = audio_tx_en_q;
  assign sync_req    = sync_req_q;
  assign key_reseed  = key_reseed_q;
  assign state_dbg   = state_q;
  assign sync_count  = sync_count_q;

endmodule

// File: tb/tb_ptt_link_scheduler.sv
// tb/tb_ptt_link_scheduler.sv - self-checking bench for ptt_link_scheduler
module tb_ptt_link_scheduler;

  localparam int D  = 4;
  localparam int G  = 8;
  localparam int SI = 3;
  localparam int TO = 40;

  logic       clk;
  logic       rst_n;
  logic       ptt_raw;
  logic       spi_tx_busy;
  logic       sync_ack;
  logic       frame_done;
  logic       ptt_clean;
  logic       master_mode;
  logic       audio_tx_en;
  logic       sync_req;
  logic       key_reseed;
  logic [2:0] state_dbg;
  logic [7:0] sync_count;
  logic       timeout_flag;

  int n_cmp = 0;
  int n_bad = 0;

  ptt_link_scheduler #(
    .DEBOUNCE_CYCLES(D),
    .GUARD_CYCLES(G),
    .SYNC_INTERVAL(SI),
    .TX_TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ptt_raw(ptt_raw),
    .spi_tx_busy(spi_tx_busy),
    .sync_ack(sync_ack),
    .frame_done(frame_done),
    .ptt_clean(ptt_clean),
    .master_mode(master_mode),
    .audio_tx_en(audio_tx_en),
    .sync_req(sync_req),
    .key_reseed(key_reseed),
    .state_dbg(state_dbg),
    .sync_count(sync_count),
    .timeout_flag(timeout_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: raw sample history, mode plus time-in-mode
  logic [15:0] raw_hist;
  logic        m_clean;
  int          m_state, m_in_state, m_frames, m_sync_cnt, m_txc, ns;
  logic        m_reseed, m_tflag, set_t, texp, all_diff;
  logic        model_valid = 1'b0;

  always @(posedge clk) begin
    model_valid = 1'b1;
    if (!rst_n) begin
      raw_hist = '0; m_clean = 1'b0; m_state = 0; m_in_state = 0; m_frames = 0;
      m_sync_cnt = 0; m_txc = 0; m_reseed = 1'b0; m_tflag = 1'b0;
    end else begin
      texp = 1'b0;
`ifdef PTT_TIMEOUT_EN
      texp = (m_txc >= TO - 1);
`endif
      ns = m_state;
      set_t = 1'b0;
      case (m_state)
        0: if (m_clean && !m_tflag) ns = 1;
        1: begin
          if (!m_clean) ns = 0;
          else if (texp) begin ns = 4; set_t = 1'b1; end
          else if (m_in_state == G - 1) ns = 2;
        end
        2: if (sync_ack) begin
          m_sync_cnt = (m_sync_cnt + 1) % 256;
          m_frames = 0;
          if (texp) begin ns = 4; set_t = 1'b1; end
          else ns = m_clean ? 3 : 4;
        end
        3: begin
          if (frame_done) m_frames++;
          if (texp) begin ns = 4; set_t = 1'b1; end
          else if (!m_clean) ns = 4;
          else if (frame_done && m_frames == SI) ns = 2;
        end
        4: if (!spi_tx_busy) ns = 5;
        5: if (m_in_state == G - 1) ns = 0;
        default: ns = 0;
      endcase
      if (set_t) m_tflag = 1'b1;
      else if (m_state == 0 && !m_clean) m_tflag = 1'b0;
      if (m_state == 0) m_txc = 0;
      else if (m_state <= 4) m_txc++;
      m_reseed = (m_state == 1 && ns == 2);
      m_in_state = (ns != m_state) ? 0 : m_in_state + 1;
      m_state = ns;
      // ptt_clean flips once the synchronized level has differed for D whole cycles
      raw_hist = {raw_hist[14:0], ptt_raw};
      all_diff = 1'b1;
      for (int k = 2; k < D + 2; k++) if (raw_hist[k] == m_clean) all_diff = 1'b0;
      if (all_diff) m_clean = ~m_clean;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (model_valid) begin
      chk("ptt_clean", ptt_clean, m_clean);
      chk("state_dbg", state_dbg, m_state);
      chk("master_mode", master_mode, (m_state >= 1 && m_state <= 4));
      chk("audio_tx_en", audio_tx_en, (m_state == 3));
      chk("sync_req", sync_req, (m_state == 2));
      chk("key_reseed", key_reseed, m_reseed);
      chk("sync_count", sync_count, 8'(m_sync_cnt));
      chk("timeout_flag", timeout_flag, m_tflag);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int s, input int max);
    int n = 0;
    while (state_dbg != 3'(s) && n < max) begin
      tick();
      n++;
    end
    chk("reach_state", state_dbg, s);
  endtask

  task automatic pulse_frame();
    frame_done = 1'b1; tick(); frame_done = 1'b0; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; ptt_raw = 1'b0; spi_tx_busy = 1'b0; sync_ack = 1'b0; frame_done = 1'b0;

    // 1: reset, stray inputs in RX, short glitch
    repeat (3) tick();
    chk("rst_state", state_dbg, 0);
    chk("rst_master", master_mode, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_sync_count", sync_count, 0);
    sync_ack = 1'b1; frame_done = 1'b1; tick(); sync_ack = 1'b0; frame_done = 1'b0;
    tick();
    chk("stray_ack_ignored", sync_count, 0);
    ptt_raw = 1'b1; tick(); tick(); ptt_raw = 1'b0;
    repeat (10) tick();
    chk("glitch_clean", ptt_clean, 0);
    chk("glitch_state", state_dbg, 0);

    // 2: press, guard, first sync with reseed
    ptt_raw = 1'b1;
    n = 0;
    while (!ptt_clean && n < 20) begin tick(); n++; end
    chk("debounce_latency", n, 6);
    tick();
    chk("enter_guard", state_dbg, 1);
    n = 0;
    while (state_dbg == 3'd1 && n < 50) begin n++; tick(); end
    chk("guard_len", n, 8);
    chk("sync_state", state_dbg, 2);
    chk("reseed_on_entry", key_reseed, 1);
    tick();
    chk("reseed_one_cycle", key_reseed, 0);
    tick();
    chk("sync_req_held", sync_req, 1);
    sync_ack = 1'b1; tick(); sync_ack = 1'b0;
    chk("first_sync_count", sync_count, 1);
    chk("audio_on", audio_tx_en, 1);

    // 3: re-sync after SI frames, no reseed
    pulse_frame();
    pulse_frame();
    frame_done = 1'b1; tick(); frame_done = 1'b0;
    chk("resync_state", state_dbg, 2);
    chk("resync_req", sync_req, 1);
    chk("resync_no_reseed", key_reseed, 0);
    sync_ack = 1'b1; tick(); sync_ack = 1'b0;
    chk("resync_count", sync_count, 2);
    chk("back_to_audio", state_dbg, 3);

    // 4: release during TX_SYNC, drain while busy, RX guard
    pulse_frame(); pulse_frame();
    frame_done = 1'b1; tick(); frame_done = 1'b0;
    chk("sync_again", state_dbg, 2);
    spi_tx_busy = 1'b1; ptt_raw = 1'b0;
    repeat (5) tick();
    frame_done = 1'b1; tick(); frame_done = 1'b0;
    repeat (4) tick();
    chk("release_clean", ptt_clean, 0);
    chk("sync_not_withdrawn", sync_req, 1);
    sync_ack = 1'b1; tick(); sync_ack = 1'b0;
    chk("drain_after_ack", state_dbg, 4);
    chk("sync_count_3", sync_count, 3);
    repeat (10) tick();
    chk("drain_while_busy", state_dbg, 4);
    chk("drain_master", master_mode, 1);
    spi_tx_busy = 1'b0;
    tick();
    chk("rx_guard", state_dbg, 5);
    n = 0;
    while (state_dbg == 3'd5 && n < 50) begin n++; tick(); end
    chk("rx_guard_len", n, 8);
    chk("rx_after_guard", state_dbg, 0);
    chk("rx_master", master_mode, 0);

    // 5: release coinciding with the re-sync frame
    ptt_raw = 1'b1;
    wait_state(2, 60);
    sync_ack = 1'b1; tick(); sync_ack = 1'b0;
    chk("s5_audio", state_dbg, 3);
    pulse_frame(); pulse_frame();
    ptt_raw = 1'b0;
    repeat (6) tick();
    chk("s5_clean_fell", ptt_clean, 0);
    chk("s5_still_audio", state_dbg, 3);
    frame_done = 1'b1; tick(); frame_done = 1'b0;
    chk("release_beats_resync", state_dbg, 4);
    wait_state(0, 40);

    // Reset mid-request drops everything
    ptt_raw = 1'b1;
    wait_state(2, 60);
    rst_n = 1'b0; ptt_raw = 1'b0;
    tick();
    chk("midrst_state", state_dbg, 0);
    chk("midrst_req", sync_req, 0);
    chk("midrst_count", sync_count, 0);
    chk("midrst_clean", ptt_clean, 0);
    rst_n = 1'b1;
    repeat (3) tick();

`ifdef PTT_TIMEOUT_EN
    // 6: held PTT times out and RX stays put until release
    ptt_raw = 1'b1;
    wait_state(1, 30);
    n = 0;
    while (state_dbg != 3'd4 && n < 100) begin
      sync_ack = (state_dbg == 3'd2);
      tick();
      n++;
    end
    sync_ack = 1'b0;
    chk("timeout_cycles", n, 40);
    chk("timeout_flag_set", timeout_flag, 1);
    wait_state(0, 40);
    repeat (20) tick();
    chk("rx_held", state_dbg, 0);
    chk("flag_held", timeout_flag, 1);
    ptt_raw = 1'b0;
    repeat (8) tick();
    chk("flag_cleared", timeout_flag, 0);
`endif

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ptt_link_scheduler.md
Name: ptt_link_scheduler

Overview:
- Sequences the half-duplex radio link for one push-to-talk transceiver node.
- Conditions the raw PTT button and drives SPI master/slave mode through guarded turnaround windows.
- Schedules a sync frame at the start of each transmission and re-sync frames every SYNC_INTERVAL audio frames.
- Sits between the PTT input and packet_manager/spi_transceiver, replacing their direct use of the raw push_to_talk.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before ptt_clean changes (1 ms at 50 MHz).
- GUARD_CYCLES, 256: turnaround dead time in TX_GUARD and RX_GUARD.
- SYNC_INTERVAL, 32: audio frames between re-sync frames; must be ≥ 1.
- TX_TIMEOUT_CYCLES, 500000000: maximum TX duration; used only with PTT_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- ptt_raw  in  1  raw push-to-talk button, asynchronous to clk
- spi_tx_busy  in  1  SPI transmitter busy
- sync_ack  in  1  one-cycle pulse: sync word (0xCAFE) fully sent
- frame_done  in  1  one-cycle pulse: one audio frame fully sent
- ptt_clean  out  1  debounced PTT level
- master_mode  out  1  SPI master select (1 = TX side)
- audio_tx_en  out  1  permits packet_manager to send audio frames
- sync_req  out  1  request for packet_manager to send a sync frame
- key_reseed  out  1  one-cycle pulse to reseed the key generator
- state_dbg  out  3  current state encoding
- sync_count  out  8  sync acks received; wraps modulo 256
- timeout_flag  out  1  TX timed out (constant 0 without PTT_TIMEOUT_EN)

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, state RX, all counters 0, synchronizer flops 0.
- PTT conditioning:
  - ptt_raw passes through a 2-flop synchronizer.
  - The debounce counter increments while the synchronized value differs from ptt_clean and clears otherwise.
  - When the counter reaches DEBOUNCE_CYCLES-1, ptt_clean toggles on the next edge and the counter clears.
  - Latency from a stable raw change to ptt_clean is 2+DEBOUNCE_CYCLES cycles.
- State encoding: RX=0, TX_GUARD=1, TX_SYNC=2, TX_AUDIO=3, TX_DRAIN=4, RX_GUARD=5. state_dbg is the registered state.
- RX:
  - master_mode=0.
  - PTT is level-sensitive: ptt_clean=1 → TX_GUARD, guard counter loaded.
- TX_GUARD:
  - master_mode=1. Counts GUARD_CYCLES cycles.
  - ptt_clean=0 before the count ends → RX (abort; nothing sent).
  - Otherwise → TX_SYNC, with key_reseed pulsed for exactly one cycle on the entry edge.
- TX_SYNC:
  - sync_req=1 and is held until sync_ack; it is never withdrawn early.
  - On sync_ack: sync_count+1, frame counter cleared.
  - If ptt_clean=1 → TX_AUDIO; if ptt_clean=0 → TX_DRAIN.
- TX_AUDIO:
  - audio_tx_en=1.
  - Each frame_done increments the frame counter.
  - frame_done while the counter equals SYNC_INTERVAL-1 → TX_SYNC (re-sync, no key_reseed).
  - ptt_clean=0 → TX_DRAIN. If ptt_clean=0 and frame_done occur in the same cycle, the frame is counted and the next state is TX_DRAIN (release beats re-sync).
- TX_DRAIN:
  - audio_tx_en=0, master_mode=1.
  - spi_tx_busy=0 → RX_GUARD, guard counter loaded. Stays while busy.
- RX_GUARD:
  - master_mode=0. Counts GUARD_CYCLES cycles → RX.
  - ptt_clean is ignored here and re-evaluated in RX.
- Timing: audio_tx_en, sync_req and master_mode are registered and valid in the first cycle of their state.
- Ignored inputs: sync_ack outside TX_SYNC; frame_done outside TX_AUDIO.
- Reset mid-operation: immediate return to RX with all outputs 0; an in-flight request is dropped.

Optional Feature:
- Macro: PTT_TIMEOUT_EN.
- Defined:
  - A TX timer clears on entry to TX_GUARD and increments in states 1–4.
  - When it reaches TX_TIMEOUT_CYCLES-1 in TX_GUARD, TX_SYNC (after ack) or TX_AUDIO → TX_DRAIN, and timeout_flag is set.
  - While timeout_flag=1, RX does not leave on ptt_clean=1.
  - timeout_flag clears when ptt_clean=0 is seen in RX.
- Undefined: no timer; timeout_flag tied to 0.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, GUARD_CYCLES=8, SYNC_INTERVAL=3.
1. Reset held for 3 cycles, then released → all outputs 0 and state_dbg=0. A 2-cycle ptt_raw glitch → ptt_clean stays 0.
2. ptt_raw held high → ptt_clean rises 6 cycles later; state_dbg=1 for 8 cycles; key_reseed pulses once; sync_req=1 until sync_ack; sync_count=1; audio_tx_en=1.
3. In TX_AUDIO, 3 frame_done pulses → third causes state_dbg=2 and sync_req=1; after ack, sync_count=2, back to 3, no key_reseed pulse.
4. Release during TX_SYNC → sync_req holds until ack, then state 4. With spi_tx_busy=1 for 10 cycles, state stays 4, then 5 for 8 cycles, then 0 with master_mode=0.
5. frame_done coinciding with the ptt_clean fall at counter=2 → next state 4, not 2.
6. PTT_TIMEOUT_EN, TX_TIMEOUT_CYCLES=40, PTT held → state 4 reached by cycle 40, timeout_flag=1, RX entered and held. After PTT is released, timeout_flag=0.
